// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with a pending-write scoreboard, optional write-to-read
// bypass and a hardware zero-fill sweep after reset. Register 0 always reads as zero.
module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     ra,
  output logic [NUM_RD*XLEN-1:0]   rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [XLEN-1:0]          wd,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr,
  output logic                     init_done
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [AW-1:0]     idx;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic              wr_en;

  assign wr_en = (state == READY) && we && (wa != '0);

  // Set is applied after clear so a producer issued on its predecessor's retire edge stays pending.
  always_comb begin
    busy_nxt = busy;
    if (we)
      busy_nxt[wa] = 1'b0;
    if (sb_set)
      busy_nxt[sb_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      idx       <= AW'(1);
      busy      <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == AW'(NREGS - 1)) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        READY: begin
          busy <= busy_nxt;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  // The array has no reset; the sweep fills it with zeros while the core is stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        regs[idx] <= '0;
      else if (wr_en)
        regs[wa] <= wd;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      logic [AW-1:0] addr;
      logic          fwd;

      assign addr = ra[g*AW +: AW];
      assign fwd  = (BYPASS != 0) && we && (wa == addr);

      // Entry 0 is never written, so its read must be forced to zero rather than taken from the array.
      always_comb begin
        rd[g*XLEN +: XLEN] = '0;
        rd_busy[g]         = 1'b0;
        if (init_done && (addr != '0)) begin
          if (fwd) begin
            rd[g*XLEN +: XLEN] = wd;
          end else begin
            rd[g*XLEN +: XLEN] = regs[addr];
            rd_busy[g]         = busy[addr];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a bypassing and a non-bypassing three-port instance share stimulus
// and are compared against an array-based reference model of the register file.
module tb_regfile_mp_sb;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_RD*AW-1:0]   ra;
  logic [NUM_RD*XLEN-1:0] rd_b, rd_n;
  logic [NUM_RD-1:0]      busy_b, busy_n;
  logic                   we, sb_set;
  logic [AW-1:0]          wa, sb_addr;
  logic [XLEN-1:0]        wd;
  logic                   init_b, init_n;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] mdl_reg [NREGS];
  bit   [NREGS-1:0] mdl_busy;
  bit               mdl_ready;
  int               mdl_edges;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NUM_RD), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rd_busy(busy_b), .we(we), .wa(wa), .wd(wd),
    .sb_set(sb_set), .sb_addr(sb_addr), .init_done(init_b)
  );

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NUM_RD), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .rd_busy(busy_n), .we(we), .wa(wa), .wd(wd),
    .sb_set(sb_set), .sb_addr(sb_addr), .init_done(init_n)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] expRd(input int p, input bit byp);
    logic [AW-1:0] a;
    a = ra[p*AW +: AW];
    if (!mdl_ready || a == 0) return '0;
    if (byp && we && wa == a) return wd;
    return mdl_reg[a];
  endfunction

  function automatic logic expBusy(input int p, input bit byp);
    logic [AW-1:0] a;
    a = ra[p*AW +: AW];
    if (!mdl_ready || a == 0) return 1'b0;
    if (byp && we && wa == a) return 1'b0;
    return mdl_busy[a];
  endfunction

  task automatic checkOutput(input string tag);
    checkVal({tag, " init_b"}, XLEN'(init_b), XLEN'(mdl_ready));
    checkVal({tag, " init_n"}, XLEN'(init_n), XLEN'(mdl_ready));
    for (int p = 0; p < NUM_RD; p++) begin
      checkVal($sformatf("%s rd_b%0d", tag, p), rd_b[p*XLEN +: XLEN], expRd(p, 1'b1));
      checkVal($sformatf("%s rd_n%0d", tag, p), rd_n[p*XLEN +: XLEN], expRd(p, 1'b0));
      checkVal($sformatf("%s busy_b%0d", tag, p), XLEN'(busy_b[p]), XLEN'(expBusy(p, 1'b1)));
      checkVal($sformatf("%s busy_n%0d", tag, p), XLEN'(busy_n[p]), XLEN'(expBusy(p, 1'b0)));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [AW-1:0] a,
                               input logic [XLEN-1:0] d, input logic s, input logic [AW-1:0] sa,
                               input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    rst     = r;
    we      = w;
    wa      = a;
    wd      = d;
    sb_set  = s;
    sb_addr = sa;
    ra      = {r2, r1, r0};
    #1;
  endtask

  // Reference update: NREGS-1 low-reset edges finish the sweep and leave every register zero.
  task automatic cycle();
    if (rst) begin
      mdl_edges = 0;
      mdl_busy  = '0;
      mdl_ready = 1'b0;
    end else if (!mdl_ready) begin
      mdl_edges++;
      if (mdl_edges == NREGS - 1) begin
        mdl_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) mdl_reg[i] = '0;
      end
    end else begin
      if (we && wa != 0) mdl_reg[wa] = wd;
      if (we) mdl_busy[wa] = 1'b0;
      if (sb_set && sb_addr != 0) mdl_busy[sb_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    mdl_ready = 1'b0;
    mdl_edges = 0;
    mdl_busy  = '0;
    for (int i = 0; i < NREGS; i++) mdl_reg[i] = '0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cycle();
    cycle();
    checkOutput("reset");

    for (int e = 0; e < NREGS - 1; e++) begin
      applyStimulus(0, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), 5'($urandom));
      checkOutput($sformatf("sweep%0d", e));
      cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sweep_done");

    for (int a = 0; a < NREGS; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 5'(a), 0, 0);
      checkVal($sformatf("zero r%0d", a), rd_b[XLEN-1:0], 32'h0);
    end

    applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 5, 0);
    checkVal("r5 port0", rd_b[31:0], 32'hDEADBEEF);
    checkVal("r5 port1", rd_b[63:32], 32'hDEADBEEF);
    checkVal("r0 port2", rd_b[95:64], 32'h0);
    checkOutput("multiport");

    applyStimulus(0, 1, 7, 32'h12345678, 0, 0, 7, 5, 7);
    checkVal("bypass r7", rd_b[31:0], 32'h12345678);
    checkVal("nobypass r7", rd_n[31:0], 32'h0);
    checkOutput("bypass");
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 7, 7);
    checkVal("nobypass r7 later", rd_n[31:0], 32'h12345678);
    checkOutput("bypass_after");

    applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    checkOutput("x0_write");
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkVal("x0 read", rd_b[31:0], 32'h0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("x0 busy", XLEN'(busy_b[0]), 32'h0);
    checkOutput("x0_sb");

    applyStimulus(0, 0, 0, 0, 1, 9, 9, 0, 0);
    cycle();
    applyStimulus(0, 1, 9, 32'hA5A5A5A5, 1, 9, 9, 9, 0);
    checkVal("sb set r9", XLEN'(busy_n[0]), 32'h1);
    checkOutput("sb_set");
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 9, 9);
    checkVal("sb set wins", XLEN'(busy_b[0]), 32'h1);
    checkOutput("sb_both");
    applyStimulus(0, 1, 9, 32'h5A5A5A5A, 0, 0, 9, 9, 9);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 9, 9);
    checkVal("sb cleared", XLEN'(busy_b[0]), 32'h0);
    checkOutput("sb_clear");

    for (int c = 0; c < 300; c++) begin
      applyStimulus(0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom, 1'($urandom),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      checkOutput($sformatf("rand%0d", c));
      cycle();
    end

    applyStimulus(0, 1, 3, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    for (int e = 0; e < 10; e++) begin
      applyStimulus(0, 1, 3, $urandom, 1, 3, 3, 3, 3);
      checkOutput($sformatf("presweep%0d", e));
      cycle();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    for (int e = 0; e < NREGS - 1; e++) begin
      applyStimulus(0, 1, 3, $urandom | 32'h1, 1, 3, 3, 3, 3);
      checkOutput($sformatf("resweep%0d", e));
      cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 3, 3);
    checkVal("r3 after resweep", rd_b[31:0], 32'h0);
    checkVal("r3 busy after resweep", XLEN'(busy_b[0]), 32'h0);
    checkOutput("resweep_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
